// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: PC-select encodings
// and return-address-stack sizing.
package pc_pkg;

  localparam logic [2:0] PS_HOLD = 3'b000;
  localparam logic [2:0] PS_INC  = 3'b001;
  localparam logic [2:0] PS_BRC  = 3'b010;
  localparam logic [2:0] PS_JMP  = 3'b011;
  localparam logic [2:0] PS_ADDA = 3'b100;
  localparam logic [2:0] PS_CALL = 3'b101;
  localparam logic [2:0] PS_RET  = 3'b110;
  localparam logic [2:0] PS_RSVD = 3'b111;

  localparam int unsigned RAS_DEPTH_DEF = 4;
  localparam int unsigned RAS_PTR_W     = $clog2(RAS_DEPTH_DEF);

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; dout always presents the top entry.
// A push while full overwrites the oldest entry and the count saturates.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned DEPTH = RAS_DEPTH_DEF,
  parameter int unsigned W     = 6
) (
  input  logic                     clk_main,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;

  // Pointer and occupancy; the pointer always addresses the top entry.
  always_ff @(posedge clk_main) begin
    if (reset) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push) begin
      ptr <= ptr + PTR_W'(1);
      if (!full) cnt <= cnt + CNT_W'(1);
    end else if (pop && !empty) begin
      ptr <= ptr - PTR_W'(1);
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Storage needs no reset: entries are only read after being pushed.
  always_ff @(posedge clk_main) begin
    if (!reset && push) mem[ptr + PTR_W'(1)] <= din;
  end

  assign dout  = mem[ptr];
  assign count = cnt;
  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC selection, PC register and sticky
// return-stack error flags around a single return-address stack.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned PC_W      = 6,
  parameter int unsigned OFF_W     = 6,
  parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEF,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic                        clk_main,
  input  logic                        reset,
  input  logic                        en,
  input  logic [2:0]                  ps,
  input  logic                        cond,
  input  logic [OFF_W-1:0]            offset,
  input  logic [PC_W-1:0]             target,
  input  logic [PC_W-1:0]             a_op,
  output logic [PC_W-1:0]             pc,
  output logic [$clog2(RAS_DEPTH):0]  ras_count,
  output logic                        ras_empty,
  output logic                        ras_full,
  output logic                        ras_ovf,
  output logic                        ras_udf
);

  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] off_ext;
  logic [PC_W-1:0] ras_dout;
  logic            push;
  logic            pop;
  logic            set_ovf;
  logic            set_udf;

  assign pc_inc  = pc + PC_W'(1);
  assign off_ext = PC_W'($signed(offset));

  // Next-PC selection and stack requests; a stall holds everything.
  always_comb begin
    pc_next = pc;
    push    = 1'b0;
    pop     = 1'b0;
    set_ovf = 1'b0;
    set_udf = 1'b0;
    if (en) begin
      case (ps)
        PS_HOLD: pc_next = pc;
        PS_INC:  pc_next = pc_inc;
        PS_BRC:  pc_next = cond ? (pc_inc + off_ext) : pc_inc;
        PS_JMP:  pc_next = target;
        PS_ADDA: pc_next = pc + a_op;
        PS_CALL: begin
          push    = 1'b1;
          set_ovf = ras_full;
          pc_next = target;
        end
        PS_RET: begin
          if (ras_empty) begin
            set_udf = 1'b1;
            pc_next = pc_inc;
          end else begin
            pop     = 1'b1;
            pc_next = ras_dout;
          end
        end
        PS_RSVD: pc_next = pc_inc;
        default: pc_next = pc_inc;
      endcase
    end
  end

  always_ff @(posedge clk_main) begin
    if (reset) begin
      pc      <= PC_W'(RESET_PC);
      ras_ovf <= 1'b0;
      ras_udf <= 1'b0;
    end else begin
      pc      <= pc_next;
      ras_ovf <= ras_ovf | set_ovf;
      ras_udf <= ras_udf | set_udf;
    end
  end

  pc_ras #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .clk_main (clk_main),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .din      (pc_inc),
    .dout     (ras_dout),
    .count    (ras_count),
    .full     (ras_full),
    .empty    (ras_empty)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequencing, branch/wrap arithmetic,
// nested calls, stack overflow/underflow and mid-sequence reset.
module tb_pc_sequencer;
  import pc_pkg::*;

  logic               clk_main = 1'b0;
  logic               reset;
  logic               en;
  logic [2:0]         ps;
  logic               cond;
  logic [5:0]         offset;
  logic [5:0]         target;
  logic [5:0]         a_op;
  logic [5:0]         pc;
  logic [RAS_PTR_W:0] ras_count;
  logic               ras_empty;
  logic               ras_full;
  logic               ras_ovf;
  logic               ras_udf;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk_main = ~clk_main;

  pc_sequencer dut (
    .clk_main  (clk_main),
    .reset     (reset),
    .en        (en),
    .ps        (ps),
    .cond      (cond),
    .offset    (offset),
    .target    (target),
    .a_op      (a_op),
    .pc        (pc),
    .ras_count (ras_count),
    .ras_empty (ras_empty),
    .ras_full  (ras_full),
    .ras_ovf   (ras_ovf),
    .ras_udf   (ras_udf)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus, then sample just after the edge.
  task automatic step(input logic rst, input logic e, input logic [2:0] p,
                      input logic c, input logic [5:0] off, input logic [5:0] tgt,
                      input logic [5:0] a);
    reset = rst; en = e; ps = p; cond = c; offset = off; target = tgt; a_op = a;
    @(posedge clk_main);
    #1;
  endtask

  task automatic op(input logic [2:0] p, input logic [5:0] tgt);
    step(1'b0, 1'b1, p, 1'b0, 6'd0, tgt, 6'd0);
  endtask

  initial begin
    // 1: reset and increment
    step(1'b1, 1'b1, PS_INC, 1'b0, 6'd0, 6'd0, 6'd0);
    step(1'b1, 1'b1, PS_INC, 1'b0, 6'd0, 6'd0, 6'd0);
    check("rst_pc", pc, 0);
    check("rst_count", ras_count, 0);
    check("rst_empty", ras_empty, 1);
    check("rst_full", ras_full, 0);
    check("rst_ovf", ras_ovf, 0);
    check("rst_udf", ras_udf, 0);
    op(PS_INC, 6'd0); check("inc1", pc, 1);
    op(PS_INC, 6'd0); check("inc2", pc, 2);
    op(PS_INC, 6'd0); check("inc3", pc, 3);
    check("inc_empty", ras_empty, 1);

    // 2: conditional relative branch
    op(PS_JMP, 6'd10); check("jmp10", pc, 10);
    step(1'b0, 1'b1, PS_BRC, 1'b1, 6'b111100, 6'd0, 6'd0); check("brc_taken", pc, 7);
    op(PS_JMP, 6'd10);
    step(1'b0, 1'b1, PS_BRC, 1'b0, 6'b111100, 6'd0, 6'd0); check("brc_not", pc, 11);

    // 3: wrap-around
    op(PS_JMP, 6'd62);
    op(PS_INC, 6'd0); check("wrap63", pc, 63);
    op(PS_INC, 6'd0); check("wrap0", pc, 0);
    op(PS_JMP, 6'd60);
    step(1'b0, 1'b1, PS_ADDA, 1'b0, 6'd0, 6'd0, 6'd9); check("adda_wrap", pc, 5);

    // 4: nested call/return, stall
    op(PS_JMP, 6'd3);
    op(PS_CALL, 6'd20); check("call1_pc", pc, 20); check("call1_cnt", ras_count, 1);
    op(PS_CALL, 6'd40); check("call2_pc", pc, 40); check("call2_cnt", ras_count, 2);
    op(PS_RET, 6'd0); check("ret1_pc", pc, 21);
    op(PS_RET, 6'd0); check("ret2_pc", pc, 4);
    check("ret_empty", ras_empty, 1);
    step(1'b0, 1'b0, PS_CALL, 1'b0, 6'd0, 6'd50, 6'd0);
    check("stall_pc", pc, 4); check("stall_cnt", ras_count, 0);
    op(PS_HOLD, 6'd33); check("hold_pc", pc, 4);
    op(PS_RSVD, 6'd33); check("rsvd_pc", pc, 5);

    // 5: overflow then underflow
    op(PS_JMP, 6'd0);
    op(PS_CALL, 6'd10);
    op(PS_CALL, 6'd20);
    op(PS_CALL, 6'd30);
    op(PS_CALL, 6'd40); check("pre_ovf", ras_ovf, 0); check("full4", ras_full, 1);
    op(PS_CALL, 6'd50);
    check("ovf", ras_ovf, 1); check("ovf_cnt", ras_count, 4); check("ovf_pc", pc, 50);
    op(PS_RET, 6'd0); check("r1", pc, 41);
    op(PS_RET, 6'd0); check("r2", pc, 31);
    op(PS_RET, 6'd0); check("r3", pc, 21);
    op(PS_RET, 6'd0); check("r4", pc, 11);
    check("pre_udf", ras_udf, 0);
    op(PS_RET, 6'd0); check("r5_pc", pc, 12); check("udf", ras_udf, 1);
    check("udf_cnt", ras_count, 0);

    // 6: reset mid-sequence, stalled and with a call pending
    step(1'b1, 1'b1, PS_HOLD, 1'b0, 6'd0, 6'd0, 6'd0);
    op(PS_CALL, 6'd10);
    op(PS_CALL, 6'd20); check("pre_rst_cnt", ras_count, 2);
    step(1'b1, 1'b0, PS_CALL, 1'b0, 6'd0, 6'd30, 6'd0);
    check("mrst_pc", pc, 0); check("mrst_cnt", ras_count, 0);
    check("mrst_ovf", ras_ovf, 0); check("mrst_udf", ras_udf, 0);
    op(PS_RET, 6'd0);
    check("post_pc", pc, 1); check("post_udf", ras_udf, 1); check("post_cnt", ras_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
